// File: rtl/mb_pkg.sv
// Shared types, default polynomials and step functions for the mb32 BIST slice.
package mb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } mb_state_t;

    // x^32+x^22+x^2+x+1
    localparam logic [31:0] DEF_LPOLY = 32'h0040_0007;
    // x^64+x^4+x^3+x+1
    localparam logic [63:0] DEF_MPOLY = 64'h0000_0000_0000_001B;

    // Galois LFSR step on the low w bits; callers truncate the result to w bits.
    function automatic logic [63:0] lfsr_next(input logic [63:0] s,
                                              input logic [63:0] poly,
                                              input int unsigned w);
        return {s[62:0], 1'b0} ^ (s[w-1] ? poly : '0);
    endfunction

    // MISR step on the low w bits: Galois shift then absorb the data word.
    function automatic logic [63:0] misr_next(input logic [63:0] m,
                                              input logic [63:0] d,
                                              input logic [63:0] poly,
                                              input int unsigned w);
        return ({m[62:0], 1'b0} ^ (m[w-1] ? poly : '0)) ^ d;
    endfunction

endpackage

// File: rtl/mb_misr.sv
// Multiple-input signature register with synchronous clear and absorb enable.
module mb_misr
    import mb_pkg::*;
#(
    parameter int unsigned     W2   = 64,
    parameter logic [W2-1:0]   POLY = W2'(DEF_MPOLY)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          clr,
    input  logic          en,
    input  logic [W2-1:0] din,
    output logic [W2-1:0] sig
);

    // Signature register: clear wins over absorb.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= W2'(misr_next(64'(sig), 64'(din), 64'(POLY), W2));
        end
    end

endmodule

// File: rtl/mb32_bist.sv
// BIST controller for the radix-4 Booth multiplier: LFSR operand generator,
// latency-aligned MISR analyser and golden-signature compare. WIDTH <= 32.
module mb32_bist
    import mb_pkg::*;
#(
    parameter int unsigned           WIDTH      = 32,
    parameter int unsigned           LAT        = 3,
    parameter int unsigned           NVEC       = 10000,
    parameter logic [WIDTH-1:0]      SEED_X     = WIDTH'(32'h0000_0001),
    parameter logic [WIDTH-1:0]      SEED_Y     = WIDTH'(32'h0000_0003),
    parameter logic [WIDTH-1:0]      LPOLY      = WIDTH'(DEF_LPOLY),
    parameter logic [2*WIDTH-1:0]    MPOLY      = (2*WIDTH)'(DEF_MPOLY),
    parameter logic [2*WIDTH-1:0]    GOLDEN_SIG = '0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    output logic [WIDTH-1:0]     mx_out,
    output logic [WIDTH-1:0]     my_out,
    input  logic [2*WIDTH-1:0]   product_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH-1:0]   signature,
    output logic [31:0]          vec_count
);

    mb_state_t          state, next_state;
    logic               load;
    logic               finish;
    logic               last_vec;
    logic [31:0]        fl_cnt;
    logic [LAT-1:0]     vpipe;
    logic [2*WIDTH-1:0] sig_next;

    assign last_vec = (vec_count == 32'(NVEC - 1));
    assign busy     = (state == RUN) || (state == FLUSH);
    assign done     = (state == DONE);

    // Value the MISR will hold after this edge, used for the final pass compare.
    assign sig_next = (2*WIDTH)'(misr_next(64'(signature), 64'(product_in), 64'(MPOLY), 2*WIDTH));

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus load/finish strobes; start is only heard in IDLE and DONE.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                if (last_vec) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                if (fl_cnt == 32'(LAT - 1)) begin
                    next_state = DONE;
                    finish     = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand LFSRs, vector/flush counters and registered pass flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mx_out    <= '0;
            my_out    <= '0;
            vec_count <= '0;
            fl_cnt    <= '0;
            pass      <= 1'b0;
        end else if (load) begin
            mx_out    <= SEED_X;
            my_out    <= SEED_Y;
            vec_count <= '0;
            fl_cnt    <= '0;
            pass      <= 1'b0;
        end else if (state == RUN) begin
            if (vec_count < 32'(NVEC)) begin
                vec_count <= vec_count + 32'd1;
            end
            if (!last_vec) begin
                mx_out <= WIDTH'(lfsr_next(64'(mx_out), 64'(LPOLY), WIDTH));
                my_out <= WIDTH'(lfsr_next(64'(my_out), 64'(LPOLY), WIDTH));
            end
        end else if (state == FLUSH) begin
            fl_cnt <= fl_cnt + 32'd1;
            if (finish) begin
                pass <= (sig_next == GOLDEN_SIG);
            end
        end
    end

    // Valid pipe tracking which products returning from the multiplier belong to a vector.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vpipe <= '0;
        end else begin
            vpipe[0] <= (state == RUN);
            for (int unsigned i = 1; i < LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
            end
        end
    end

    mb_misr #(
        .W2   (2*WIDTH),
        .POLY (MPOLY)
    ) u_misr (
        .CLK (CLK),
        .RST (RST),
        .clr (load),
        .en  (vpipe[LAT-1]),
        .din (product_in),
        .sig (signature)
    );

endmodule

// File: doc/mb32_bist.md
Name: mb32_bist

Overview:
On-chip built-in self-test controller for the pipelined radix-4 Booth multiplier (mb32_top). It sits on the operand/product boundary of mb32_top.
- Generator side: drives pseudo-random operand pairs from two Galois LFSRs.
- Analyser side: compacts the returning products into a MISR signature, aligned to the multiplier's pipeline latency.
- Result: flags pass/fail against a golden signature. It is the hardware counterpart of the simulation checker.

Parameters:
WIDTH, 32, operand width; product width is 2*WIDTH
LAT, 3, multiplier latency in clock cycles from operand to product (>=1)
NVEC, 10000, number of operand pairs issued per run (>=1)
SEED_X, 32'h00000001, mx LFSR seed (nonzero)
SEED_Y, 32'h00000003, my LFSR seed (nonzero)
LPOLY, 32'h00400007, LFSR feedback mask (x^32+x^22+x^2+x+1)
MPOLY, 64'h000000000000001B, MISR feedback mask (x^64+x^4+x^3+x+1)
GOLDEN_SIG, 64'h0, expected final signature

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  asynchronous reset, active-high
start  in  1  one-cycle request to begin a run
mx_out  out  WIDTH  operand X to multiplier (registered)
my_out  out  WIDTH  operand Y to multiplier (registered)
product_in  in  2*WIDTH  product from multiplier
busy  out  1  high in RUN and FLUSH
done  out  1  high in DONE
pass  out  1  valid when done; 1 iff signature==GOLDEN_SIG
signature  out  2*WIDTH  current MISR contents
vec_count  out  32  operand pairs issued in current/last run

Behaviour:
- Reset (async, RST=1):
  - state=IDLE.
  - mx_out=0, my_out=0, signature=0, vec_count=0.
  - busy=0, done=0, pass=0.
  - Valid pipe cleared.
- LFSR step: nxt(s) = {s[WIDTH-2:0],1'b0} ^ (s[WIDTH-1] ? LPOLY : 0).
- MISR step: m <= ({m[2W-2:0],1'b0} ^ (m[2W-1] ? MPOLY : 0)) ^ product_in.
- IDLE:
  - Outputs hold.
  - On start: mx_out<=SEED_X, my_out<=SEED_Y, signature<=0, vec_count<=0, pass<=0, state<=RUN.
- RUN (exactly NVEC cycles):
  - The pair on mx_out/my_out during each cycle is one vector.
  - Each edge: vec_count<=vec_count+1.
  - While vec_count<NVEC-1: mx_out<=nxt(mx_out), my_out<=nxt(my_out).
  - At the edge where vec_count==NVEC-1: state<=FLUSH and operands hold their last value.
- Valid pipe: v[0]<=(state==RUN); v[i]<=v[i-1] for i=1..LAT-1.
  - MISR updates only on edges where v[LAT-1]==1.
  - The product for operands presented in cycle c is therefore absorbed at the end of cycle c+LAT.
- FLUSH:
  - Lasts exactly LAT cycles.
  - The last absorption happens on the final FLUSH edge.
  - Then state<=DONE, with pass<=(MISR next-value==GOLDEN_SIG) registered on the same edge.
- DONE:
  - done=1; signature and pass are frozen.
  - start restarts exactly as from IDLE (re-seed, clear), going directly to RUN.
- start asserted during RUN or FLUSH is ignored. It has no effect on counters or signature.
- busy is high for exactly NVEC+LAT cycles per run.
- RST mid-run: immediate return to reset values. A partial run leaves no residue.
- vec_count saturates at NVEC (never wraps within a run).

Decomposition:
- Shared package mb_pkg:
  - state enum {IDLE, RUN, FLUSH, DONE}.
  - Default LPOLY/MPOLY constants.
  - Functions lfsr_next and misr_next.
- One sub-module, mb_misr: 2*WIDTH signature register with enable and clear.
- LFSRs, FSM and valid pipe live in mb32_bist.

Test Plan:
The bench uses a behavioural multiplier model with LAT-cycle delay, plus parameter overrides NVEC=4, LAT=3, SEED_X=1, SEED_Y=3.
1. Reset check: hold RST=1 -> all outputs 0, busy=0, done=0.
2. Nominal run: pulse start; mx_out must be 1,2,4,8 and my_out 3,6,12,24 on consecutive cycles.
   - Signature after the run = 64'h88 (3, 10, 36, 136).
   - busy high for 7 cycles, then done=1.
   - With GOLDEN_SIG=64'h88, pass=1.
3. Fault detection: model flips product_in bit 0 for the third vector -> signature != 64'h88, pass=0, done=1.
4. LFSR feedback: SEED_X=32'h80000000 -> second mx_out = 32'h00400007.
5. Control corners:
   - start held high throughout RUN/FLUSH -> identical timing and signature to scenario 2.
   - start in DONE -> a second run yields 64'h88 again and vec_count=4.
6. Reset mid-run: assert RST during cycle 2 of RUN -> outputs return to 0 asynchronously.
   - A subsequent start reproduces scenario 2 exactly.
